// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Purpose  : Shared UART definitions: frame state encoding and parity codes,
//            common to the transmitter and receiver.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

  // Frame state; the encoding is shared with the receiver
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd3,
    PARITY = 3'd4
  } uart_state_t;

  // Parity selection codes
  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

endpackage
`default_nettype wire

// File: rtl/uart_tx_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_if
// Purpose  : Bus-side handshake between the register logic (master) and the
//            UART transmitter (slave), plus the serial line and status.
// Revision : 1.0 - initial release
// ============================================================================
interface uart_tx_if #(
  parameter int data_bits = 8
) ();

  logic [data_bits-1:0] tx_data_in;
  logic                 we;
  logic                 tx;
  logic                 tx_ready;
  logic                 tx_done;

  modport master (
    output tx_data_in,
    output we,
    input  tx,
    input  tx_ready,
    input  tx_done
  );

  modport slave (
    input  tx_data_in,
    input  we,
    output tx,
    output tx_ready,
    output tx_done
  );

endinterface
`default_nettype wire

// File: rtl/uart_baud_gen.sv
`default_nettype none
// ============================================================================
// Module   : uart_baud_gen
// Purpose  : Bit-time counter. Counts 0..clock_divide-1, wraps, and pulses
//            tick for one cycle in the final cycle of every bit.
// Revision : 1.0 - initial release
// ============================================================================
module uart_baud_gen #(
  parameter int clock_divide = 2604
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int                 c_CNT_W = $clog2(clock_divide) + 1;
  localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(clock_divide - 1);

  logic [c_CNT_W-1:0] r_cnt;

  // Free-running bit-time counter, held at zero while the owner is idle
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_cnt <= '0;
    end else if (r_cnt == c_LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign tick = (r_cnt == c_LAST);

endmodule
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx
// Purpose  : UART transmitter. Serialises a parallel word as start bit,
//            LSB-first data, optional parity and 1-2 stop bits on tx.
//            Optional macro UART_TX_HOLD_EN adds a one-entry holding register
//            so a second word can be queued during a frame and sent
//            back-to-back.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx
  import uart_pkg::*;
#(
  parameter int clk_freq    = 50000000,
  parameter int baud_rate   = 19200,
  parameter int data_bits   = 8,
  parameter int parity_type = 0,
  parameter int stop_bits   = 1
) (
  input  logic      clk,
  input  logic      rst,
  uart_tx_if.slave  s_if
);

  localparam int                 c_CLOCK_DIVIDE = clk_freq / baud_rate;
  localparam int                 c_BIT_W        = $clog2(data_bits);
  localparam logic [c_BIT_W-1:0] c_LAST_BIT     = c_BIT_W'(data_bits - 1);
  localparam logic [1:0]         c_STOP_LOAD    = 2'(stop_bits - 1);
  localparam bit                 c_HAS_PARITY   = (parity_type != PARITY_NONE);

  uart_state_t          r_state;
  uart_state_t          w_state_next;
  logic                 w_tick;
  logic                 w_clr;
  logic [data_bits-1:0] r_shift;
  logic [data_bits-1:0] r_data;
  logic [data_bits-1:0] w_shift_next;
  logic [data_bits-1:0] w_load_data;
  logic [c_BIT_W-1:0]   r_bit_idx;
  logic [1:0]           r_stop_cnt;
  logic                 r_tx;
  logic                 w_tx_next;
  logic                 w_tx_ready;
  logic                 w_tx_done;
  logic                 w_accept;
  logic                 w_load;
  logic                 w_last_bit;
  logic                 w_stop_end;
  logic                 w_parity;

  uart_baud_gen #(
    .clock_divide (c_CLOCK_DIVIDE)
  ) u_baud_gen (
    .clk  (clk),
    .rst  (rst),
    .clr  (w_clr),
    .tick (w_tick)
  );

  // Bit timing restarts from zero on the first START cycle after idle
  assign w_clr      = (r_state == IDLE);
  assign w_accept   = s_if.we && w_tx_ready;
  assign w_last_bit = (r_bit_idx == c_LAST_BIT);
  assign w_stop_end = (r_state == STOP) && w_tick && (r_stop_cnt == 2'd0);

`ifdef UART_TX_HOLD_EN
  logic [data_bits-1:0] r_hold;
  logic                 r_hold_valid;
  logic                 w_from_hold;
  logic                 w_hold_wr;

  // A held word starts either from idle or straight after the last stop bit
  assign w_from_hold = r_hold_valid && ((r_state == IDLE) || w_stop_end);
  assign w_hold_wr   = w_accept && (r_state != IDLE);
  assign w_load      = w_from_hold || (w_accept && (r_state == IDLE));
  assign w_load_data = w_from_hold ? r_hold : s_if.tx_data_in;

  // Holding register: filled by a write during a frame, drained on transfer
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hold_valid <= 1'b0;
      r_hold       <= '0;
    end else if (w_from_hold) begin
      r_hold_valid <= 1'b0;
    end else if (w_hold_wr) begin
      r_hold_valid <= 1'b1;
      r_hold       <= s_if.tx_data_in;
    end
  end
`else
  // Without a holding register writes are only taken while idle
  assign w_load      = w_accept;
  assign w_load_data = s_if.tx_data_in;
`endif

  // Parity bit over the latched word
  always_comb begin
    w_parity = 1'b0;
    case (parity_type)
      PARITY_ODD:  w_parity = ~^r_data;
      PARITY_EVEN: w_parity = ^r_data;
      default:     w_parity = 1'b0;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_load) w_state_next = START;
      end
      START: begin
        if (w_tick) w_state_next = DATA;
      end
      DATA: begin
        if (w_tick && w_last_bit) w_state_next = c_HAS_PARITY ? PARITY : STOP;
      end
      PARITY: begin
        if (w_tick) w_state_next = STOP;
      end
      STOP: begin
        if (w_stop_end) w_state_next = w_load ? START : IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Shift register next value: load a new word or shift at the end of a data bit
  always_comb begin
    w_shift_next = r_shift;
    if (w_load) begin
      w_shift_next = w_load_data;
    end else if ((r_state == DATA) && w_tick) begin
      w_shift_next = r_shift >> 1;
    end
  end

  // FSM outputs; the line level is precomputed from the next state so tx is a flop
  always_comb begin
`ifdef UART_TX_HOLD_EN
    w_tx_ready = !r_hold_valid;
`else
    w_tx_ready = (r_state == IDLE);
`endif
    w_tx_done = w_stop_end;
    w_tx_next = 1'b1;
    case (w_state_next)
      START:   w_tx_next = 1'b0;
      DATA:    w_tx_next = w_shift_next[0];
      PARITY:  w_tx_next = w_parity;
      default: w_tx_next = 1'b1;
    endcase
  end

  // Datapath registers: line, shift register, latched word, bit and stop counters
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx       <= 1'b1;
      r_shift    <= '0;
      r_data     <= '0;
      r_bit_idx  <= '0;
      r_stop_cnt <= 2'd0;
    end else begin
      r_tx    <= w_tx_next;
      r_shift <= w_shift_next;
      if (w_load) r_data <= w_load_data;

      if ((r_state == DATA) && w_tick) begin
        r_bit_idx <= w_last_bit ? '0 : r_bit_idx + 1'b1;
      end else if (r_state != DATA) begin
        r_bit_idx <= '0;
      end

      if ((w_state_next == STOP) && (r_state != STOP)) begin
        r_stop_cnt <= c_STOP_LOAD;
      end else if ((r_state == STOP) && w_tick && (r_stop_cnt != 2'd0)) begin
        r_stop_cnt <= r_stop_cnt - 2'd1;
      end
    end
  end

  assign s_if.tx       = r_tx;
  assign s_if.tx_ready = w_tx_ready;
  assign s_if.tx_done  = w_tx_done;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx
// Purpose  : Directed self-checking bench for uart_tx (8N1 and 7E2 instances,
//            clock_divide = 10). Expectations adapt when UART_TX_HOLD_EN is set.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx;

  localparam int c_CF   = 1000000;
  localparam int c_BR   = 100000;
  localparam int c_BT   = 10;
  localparam int c_NMAX = 300;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       drv_we   = 1'b0;
  logic       sel      = 1'b0;
  logic [7:0] drv_data = 8'h00;
  logic       mon_tx, mon_done, mon_rdy;

  uart_tx_if #(.data_bits(8)) if8 ();
  uart_tx_if #(.data_bits(7)) if7 ();

  assign if8.we         = drv_we & ~sel;
  assign if8.tx_data_in = drv_data;
  assign if7.we         = drv_we & sel;
  assign if7.tx_data_in = drv_data[6:0];

  assign mon_tx   = sel ? if7.tx       : if8.tx;
  assign mon_done = sel ? if7.tx_done  : if8.tx_done;
  assign mon_rdy  = sel ? if7.tx_ready : if8.tx_ready;

  uart_tx #(
    .clk_freq (c_CF), .baud_rate (c_BR), .data_bits (8), .parity_type (0), .stop_bits (1)
  ) u_dut8 (
    .clk (clk), .rst (rst), .s_if (if8.slave)
  );

  uart_tx #(
    .clk_freq (c_CF), .baud_rate (c_BR), .data_bits (7), .parity_type (2), .stop_bits (2)
  ) u_dut7 (
    .clk (clk), .rst (rst), .s_if (if7.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cur_cyc = -1;

  logic       e_tx   [0:c_NMAX-1];
  logic       e_done [0:c_NMAX-1];
  logic       e_rdy  [0:c_NMAX-1];
  logic       w_en   [0:c_NMAX-1];
  logic       r_en   [0:c_NMAX-1];
  logic [7:0] w_dat  [0:c_NMAX-1];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h, want %0h", tag, cur_cyc, obs, exp);
    end
  endtask

  task automatic clr_exp();
    for (int i = 0; i < c_NMAX; i++) begin
      e_tx[i] = 1'b1; e_done[i] = 1'b0; e_rdy[i] = 1'b1;
      w_en[i] = 1'b0; r_en[i] = 1'b0; w_dat[i] = 8'h00;
    end
  endtask

  // seq bit k is the line level during bit time k of the frame
  task automatic add_frame(input int s, input logic [15:0] seq, input int nbits);
    for (int i = 0; i < nbits * c_BT; i++) begin
      e_tx[s + i] = seq[i / c_BT];
`ifndef UART_TX_HOLD_EN
      e_rdy[s + i] = 1'b0;
`endif
    end
    e_done[s + nbits * c_BT - 1] = 1'b1;
  endtask

  task automatic run(input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk); #1;
      cur_cyc  = c;
      drv_we   = w_en[c];
      drv_data = w_dat[c];
      rst      = r_en[c];
      @(negedge clk);
      check("tx", {31'd0, mon_tx}, {31'd0, e_tx[c]});
      check("tx_done", {31'd0, mon_done}, {31'd0, e_done[c]});
      check("tx_ready", {31'd0, mon_rdy}, {31'd0, e_rdy[c]});
    end
    @(posedge clk); #1;
    drv_we = 1'b0;
    rst    = 1'b0;
  endtask

  initial begin
    // Reset values on both instances
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tx8", {31'd0, if8.tx}, 32'd1);
    check("rst_rdy8", {31'd0, if8.tx_ready}, 32'd1);
    check("rst_done8", {31'd0, if8.tx_done}, 32'd0);
    check("rst_tx7", {31'd0, if7.tx}, 32'd1);
    check("rst_rdy7", {31'd0, if7.tx_ready}, 32'd1);
    check("rst_done7", {31'd0, if7.tx_done}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // 8N1, 0xA5: 0 | 1,0,1,0,0,1,0,1 | 1 ; done in cycle 100
    sel = 1'b0;
    clr_exp();
    w_en[0] = 1'b1; w_dat[0] = 8'hA5;
    add_frame(1, 16'b00_0000_0011_0100_1010, 10);
    run(110);

    // 7E2, 0x43: data 1,1,0,0,0,0,1 ; parity 1 ; stops 1,1 ; 110 cycles
    sel = 1'b1;
    clr_exp();
    w_en[0] = 1'b1; w_dat[0] = 8'h43;
    add_frame(1, 16'b0000_0111_1000_0110, 11);
    run(120);

    // Write 0x11, then 0x22 during cycle 50
    sel = 1'b0;
    clr_exp();
    w_en[0]  = 1'b1; w_dat[0]  = 8'h11;
    w_en[50] = 1'b1; w_dat[50] = 8'h22;
    add_frame(1, 16'b0000_0010_0010_0010, 10);
`ifdef UART_TX_HOLD_EN
    add_frame(101, 16'b0000_0010_0100_0100, 10);
    for (int i = 51; i <= 100; i++) e_rdy[i] = 1'b0;
    run(215);
`else
    run(130);
`endif

    // Reset during cycle 35, then a clean frame of 0x3C written in cycle 40
    clr_exp();
    w_en[0]  = 1'b1; w_dat[0]  = 8'hA5;
    r_en[35] = 1'b1;
    w_en[40] = 1'b1; w_dat[40] = 8'h3C;
    add_frame(1, 16'b00_0000_0011_0100_1010, 10);
    for (int i = 36; i <= 100; i++) begin
      e_tx[i] = 1'b1; e_done[i] = 1'b0; e_rdy[i] = 1'b1;
    end
    add_frame(41, 16'b0000_0010_0111_1000, 10);
    run(150);

`ifndef UART_TX_HOLD_EN
    // we held high: frames of 0x5A start in cycles 1 and 102
    clr_exp();
    for (int i = 0; i <= 101; i++) begin
      w_en[i] = 1'b1; w_dat[i] = 8'h5A;
    end
    add_frame(1, 16'b0000_0010_1011_0100, 10);
    add_frame(102, 16'b0000_0010_1011_0100, 10);
    run(210);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
